// File: rtl/k12a_sevenseg_scanner_if.sv
// rtl/k12a_sevenseg_scanner_if.sv - display-value load port for the seven-segment scanner
// Carries load_data (4 bits per digit, digit 0 in bits [3:0]) with a valid/ready handshake.
// master: the requester (CPU I/O register block); slave: the scanner.
interface k12a_sevenseg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_valid;
    logic                    load_ready;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/k12a_sevenseg_scanner.sv
// rtl/k12a_sevenseg_scanner.sv - time-multiplexed hex digit scanner with tear-free display register
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   load         slave side of the load handshake (load_data / load_valid / load_ready)
//   lz_enable    1 = suppress leading zeros (digit 0 is always shown)
//   digit_value  nibble for the shared decoder, registered
//   digit_enable one-hot digit drive, all-zero = blank, registered
//   frame_start  one-cycle pulse on the first output cycle of slot 0
module k12a_sevenseg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1024,
    parameter int GAP        = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    k12a_sevenseg_scanner_if.slave    load,
    input  logic                      lz_enable,
    output logic [3:0]                digit_value,
    output logic [NUM_DIGITS-1:0]     digit_enable,
    output logic                      frame_start
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } state_t;

    // Slot position 0 is a blank cycle unless there is no gap at all.
    localparam state_t RST_STATE = (GAP > 0) ? ST_BLANK : ST_ON;

    logic [CW-1:0]             count, count_n;
    logic [IW-1:0]             idx, idx_n;
    logic [4*NUM_DIGITS-1:0]   display, staged;
    logic                      pending, pending_n;
    logic                      load_ready_q;
    state_t                    state_q, state_n;
    logic                      slot_end, frame_end, xfer;
    logic                      in_gap_n;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [3:0]                nib;
    logic [NUM_DIGITS-1:0]     enable_n;
    logic                      frame_start_n;

    assign load.load_ready = load_ready_q;
    assign xfer            = load.load_valid && load_ready_q;

    // Slot/digit counters
    always_comb begin
        slot_end  = (count == CNT_MAX);
        frame_end = slot_end && (idx == IDX_MAX);
        count_n   = slot_end ? '0 : count + CW'(1);
        idx_n     = idx;
        if (slot_end) begin
            idx_n = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end
    end

    // Gap membership of the position the counter moves to; with no gap the
    // comparison would be constant, so it is not built at all.
    generate
        if (GAP == 0) begin : g_nogap
            assign in_gap_n = 1'b0;
        end else begin : g_gap
            assign in_gap_n = (count_n < CW'(GAP));
        end
    endgenerate

    // Per-slot FSM next state
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_BLANK: if (!in_gap_n) state_n = ST_ON;
            ST_ON:    if (in_gap_n)  state_n = ST_BLANK;
            default:  state_n = RST_STATE;
        endcase
    end

    // Digit i (i>0) is a leading zero when it and every digit above it are 0.
    always_comb begin
        lz_mask = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = ((display >> (4 * i)) == '0);
        end
    end

    // Output values for the current position, registered below. A suppressed
    // digit is zero by definition, so the nibble is passed through unchanged.
    always_comb begin
        nib           = display[{idx, 2'b00} +: 4];
        enable_n      = '0;
        frame_start_n = (idx == '0) && (count == '0);
        if (state_q == ST_ON && !(lz_enable && lz_mask[idx])) begin
            enable_n = NUM_DIGITS'(1) << idx;
        end
    end

    // A transfer can only occur with pending clear, so it never collides with
    // the display update; a transfer on a boundary waits for the next one.
    always_comb begin
        pending_n = pending;
        if (frame_end) pending_n = 1'b0;
        if (xfer)      pending_n = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            idx          <= '0;
            state_q      <= RST_STATE;
            display      <= '0;
            staged       <= '0;
            pending      <= 1'b0;
            load_ready_q <= 1'b0;
            digit_enable <= '0;
            digit_value  <= '0;
            frame_start  <= 1'b0;
        end else begin
            count        <= count_n;
            idx          <= idx_n;
            state_q      <= state_n;
            pending      <= pending_n;
            load_ready_q <= !pending_n;
            digit_enable <= enable_n;
            digit_value  <= nib;
            frame_start  <= frame_start_n;
            if (xfer) begin
                staged <= load.load_data;
            end
            if (frame_end && pending) begin
                display <= staged;
            end
        end
    end
endmodule
